// File: rtl/uart_tx_sched.sv
// Arbitrates FIFO and injection bytes onto one txuartlite; grant->write/pop 1 clk, registered outputs.
// Waits for tx busy to rise and fall (4-clk rise timeout) plus GAP_CYCLES before the next grant.
module uart_tx_sched #(
  parameter int GAP_CYCLES = 0,
  parameter int CNTW       = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mode,
  input  logic            i_step,
  input  logic            i_fifo_empty_n,
  input  logic [7:0]      i_fifo_data,
  output logic            o_fifo_rd,
  input  logic            i_inj_valid,
  input  logic [7:0]      i_inj_data,
  output logic            o_inj_ready,
  output logic            o_tx_wr,
  output logic [7:0]      o_tx_data,
  input  logic            i_tx_busy,
  output logic            o_empty_hit,
  output logic [CNTW-1:0] o_count
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t          state_q, state_d;
  logic            tok_q, tok_d;
  logic            rr_q, rr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            rdy_q, rdy_d;
  logic            hit_q, hit_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            grant_fifo, grant_inj;

  always_comb begin
    state_d    = state_q;
    tok_d      = tok_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    rdy_d      = 1'b0;
    hit_d      = 1'b0;
    count_d    = count_q;
    grant_fifo = 1'b0;
    grant_inj  = 1'b0;

    if (!i_mode) begin
      tok_d = 1'b0;
    end else if (i_step) begin
      tok_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_mode && i_step && !i_fifo_empty_n && !i_inj_valid) begin
          hit_d  = 1'b1;
          data_d = 8'h00;
          tok_d  = 1'b0;
        end else if (!i_tx_busy && (!i_mode || tok_q)) begin
          // rr_q: 0 favours the FIFO, 1 favours injection on a tie
          if (i_fifo_empty_n && i_inj_valid) begin
            grant_inj  = rr_q;
            grant_fifo = !rr_q;
            rr_d       = !rr_q;
          end else begin
            grant_fifo = i_fifo_empty_n;
            grant_inj  = i_inj_valid;
          end
          if (grant_fifo || grant_inj) begin
            data_d  = grant_fifo ? i_fifo_data : i_inj_data;
            wr_d    = 1'b1;
            rd_d    = grant_fifo;
            rdy_d   = grant_inj;
            count_d = count_q + CNTW'(1);
            tok_d   = 1'b0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        cnt_d   = 8'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // a transmitter that never raises busy releases us after 4 clocks
        if (i_tx_busy || cnt_q == 8'd3) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          cnt_d   = 8'd0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tok_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdy_q   <= 1'b0;
      hit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      hit_q   <= hit_d;
      count_q <= count_d;
    end
  end

  assign o_tx_wr     = wr_q;
  assign o_fifo_rd   = rd_q;
  assign o_inj_ready = rdy_q;
  assign o_tx_data   = data_q;
  assign o_empty_hit = hit_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: FIFO, injector and txuartlite busy modelled at the negedge,
// written bytes scored against an expected-byte queue filled when stimulus is applied.
module tb_uart_tx_sched;

  localparam int GAP      = 5;
  localparam int CW       = 4;
  localparam int BUSY_LEN = 10;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_mode;
  logic          i_step;
  logic          i_fifo_empty_n;
  logic [7:0]    i_fifo_data;
  logic          o_fifo_rd;
  logic          i_inj_valid;
  logic [7:0]    i_inj_data;
  logic          o_inj_ready;
  logic          o_tx_wr;
  logic [7:0]    o_tx_data;
  logic          i_tx_busy;
  logic          o_empty_hit;
  logic [CW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  uart_tx_sched #(.GAP_CYCLES(GAP), .CNTW(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_mode         (i_mode),
    .i_step         (i_step),
    .i_fifo_empty_n (i_fifo_empty_n),
    .i_fifo_data    (i_fifo_data),
    .o_fifo_rd      (o_fifo_rd),
    .i_inj_valid    (i_inj_valid),
    .i_inj_data     (i_inj_data),
    .o_inj_ready    (o_inj_ready),
    .o_tx_wr        (o_tx_wr),
    .o_tx_data      (o_tx_data),
    .i_tx_busy      (i_tx_busy),
    .o_empty_hit    (o_empty_hit),
    .o_count        (o_count)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, inj_cnt = 0, hit_cnt = 0;
  int fall_cyc = 0, prev_wr_cyc = 0, wr_gap = 0, wr_int = 0, busy_left = 0;
  bit busy_en = 1'b1;
  int w0, r0, i0, h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sync_fifo();
    i_fifo_empty_n = (fifo_q.size() > 0);
    i_fifo_data    = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_fifo(input logic [7:0] b, input bit expect_it);
    fifo_q.push_back(b);
    if (expect_it) exp_q.push_back(b);
    sync_fifo();
  endtask

  task automatic tick(input int n = 1);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      cyc++;
      if (o_tx_wr) begin
        check("busy_at_wr", 32'(i_tx_busy), 32'd0);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_data", 32'(o_tx_data), 32'(e));
        end
        wr_cnt++;
        wr_gap      = cyc - fall_cyc;
        wr_int      = cyc - prev_wr_cyc;
        prev_wr_cyc = cyc;
      end
      if (o_empty_hit) hit_cnt++;
      if (o_inj_ready) begin
        check("inj_with_wr", 32'(o_tx_wr), 32'd1);
        inj_cnt++;
        i_inj_valid = 1'b0;
        i_inj_data  = 8'h00;
      end
      if (o_fifo_rd) begin
        check("rd_with_wr", 32'(o_tx_wr), 32'd1);
        rd_cnt++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        sync_fifo();
      end
      // transmitter: busy rises right after the write strobe and lasts BUSY_LEN clocks
      if (o_tx_wr && busy_en) begin
        i_tx_busy = 1'b1;
        busy_left = BUSY_LEN;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          i_tx_busy = 1'b0;
          fall_cyc  = cyc;
        end
      end
    end
  endtask

  task automatic step();
    i_step = 1'b1;
    tick(1);
    i_step = 1'b0;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_tx_wr"},     32'(o_tx_wr),     32'd0);
    check({pfx, "_fifo_rd"},   32'(o_fifo_rd),   32'd0);
    check({pfx, "_inj_ready"}, 32'(o_inj_ready), 32'd0);
    check({pfx, "_empty_hit"}, 32'(o_empty_hit), 32'd0);
    check({pfx, "_tx_data"},   32'(o_tx_data),   32'd0);
    check({pfx, "_count"},     32'(o_count),     32'd0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_mode      = 1'b0;
    i_step      = 1'b0;
    i_inj_valid = 1'b0;
    i_inj_data  = 8'h00;
    i_tx_busy   = 1'b0;
    sync_fifo();
    tick(3);
    check_zero_outputs("rst");
    i_rst_n = 1'b1;
    tick(2);

    // auto drain of three FIFO bytes
    w0 = wr_cnt; r0 = rd_cnt;
    push_fifo(8'h41, 1); push_fifo(8'h42, 1); push_fifo(8'h43, 1);
    tick(100);
    check("auto_wr", 32'(wr_cnt - w0), 32'd3);
    check("auto_rd", 32'(rd_cnt - r0), 32'd3);
    check("auto_count", 32'(o_count), 32'd3);
    // busy fall seen next edge, GAP idle clocks, then the grant edge
    check("gap_clocks", 32'(wr_gap), 32'(GAP + 2));

    // step mode: nothing moves without a step; empty step blanks the LEDs
    i_mode = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    push_fifo(8'h55, 1);
    tick(200);
    check("step_hold", 32'(wr_cnt - w0), 32'd0);
    step();
    tick(40);
    check("step_one_wr", 32'(wr_cnt - w0), 32'd1);
    check("step_one_rd", 32'(rd_cnt - r0), 32'd1);
    h0 = hit_cnt;
    step();
    tick(1);
    check("empty_hit", 32'(hit_cnt - h0), 32'd1);
    check("empty_leds", 32'(o_tx_data), 32'd0);
    push_fifo(8'h66, 1);
    tick(50);
    check("no_token_kept", 32'(wr_cnt - w0), 32'd1);
    step();
    tick(40);
    check("step_after_empty", 32'(wr_cnt - w0), 32'd2);

    // both sources pending, pointer at FIFO: 0x10, 0xA5, 0x11
    i_mode = 1'b0;
    w0 = wr_cnt; i0 = inj_cnt;
    push_fifo(8'h10, 1);
    i_inj_valid = 1'b1;
    i_inj_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    push_fifo(8'h11, 1);
    tick(100);
    check("rr_wr", 32'(wr_cnt - w0), 32'd3);
    check("rr_inj_ready", 32'(inj_cnt - i0), 32'd1);

    // three steps inside one busy window yield one further byte only
    i_mode = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    push_fifo(8'h31, 1); push_fifo(8'h32, 1); push_fifo(8'h33, 0); push_fifo(8'h34, 0);
    step();
    tick(2);
    for (int k = 0; k < 3; k++) begin
      step();
      tick(1);
    end
    tick(60);
    check("token_single_wr", 32'(wr_cnt - w0), 32'd2);
    check("token_single_rd", 32'(rd_cnt - r0), 32'd2);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h34);
    i_mode = 1'b0;
    tick(80);
    check("mode_switch_drain", 32'(wr_cnt - w0), 32'd4);

    // transmitter never asserts busy: SEND + 4 WAIT_BUSY + WAIT_DONE + GAP + grant
    busy_en = 1'b0;
    w0 = wr_cnt;
    push_fifo(8'h71, 1); push_fifo(8'h72, 1);
    tick(60);
    check("nobusy_wr", 32'(wr_cnt - w0), 32'd2);
    check("nobusy_interval", 32'(wr_int), 32'(GAP + 7));
    busy_en = 1'b1;

    // 18 bytes sent so far with a 4-bit counter
    push_fifo(8'h81, 1); push_fifo(8'h82, 1); push_fifo(8'h83, 1); push_fifo(8'h84, 1);
    tick(120);
    check("count_wrap", 32'(o_count), 32'd2);

    // reset while waiting for busy to drop with a token held
    i_mode = 1'b1;
    push_fifo(8'hC0, 1); push_fifo(8'hC1, 1); push_fifo(8'hC2, 1);
    step();
    tick(3);
    step();
    tick(1);
    i_rst_n = 1'b0;
    tick(1);
    check_zero_outputs("midrst");
    i_rst_n = 1'b1;
    i_mode  = 1'b0;
    w0 = wr_cnt;
    tick(100);
    check("post_rst_wr", 32'(wr_cnt - w0), 32'd2);
    check("post_rst_count", 32'(o_count), 32'd2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);
    check("total_pops", 32'(rd_cnt), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Scheduler between the receive FIFO (ufifo, first-word fall-through), a byte-injection requester and the single txuartlite transmitter.
- Decides which requester owns the transmitter and sequences FIFO pops against txuartlite busy.
- Supports free-running drain (auto) or one byte per step pulse (step, driven by a debounced button).
- Holds the last byte sent for the board LEDs.

Parameters:
- GAP_CYCLES, 0, idle clocks inserted after o_tx_busy falls before the next grant (0..255).
- CNTW, 16, width of the sent-byte counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_mode  in  1  0 = auto drain, 1 = step mode.
- i_step  in  1  single-cycle step pulse; ignored when i_mode=0.
- i_fifo_empty_n  in  1  FIFO holds at least one byte.
- i_fifo_data  in  8  FIFO head byte; valid while i_fifo_empty_n=1.
- o_fifo_rd  out  1  single-cycle FIFO pop.
- i_inj_valid  in  1  injection requester has a byte.
- i_inj_data  in  8  injection byte; stable while i_inj_valid=1.
- o_inj_ready  out  1  single-cycle accept of the injection byte.
- o_tx_wr  out  1  single-cycle write strobe to txuartlite.
- o_tx_data  out  8  byte to txuartlite; also drives the LEDs.
- i_tx_busy  in  1  txuartlite o_busy.
- o_empty_hit  out  1  pulse: a step found no source pending.
- o_count  out  CNTW  bytes sent; wraps.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All strobes 0; o_tx_data=0; o_count=0.
  - Step token=0; round-robin pointer=FIFO; gap counter=0.
- All outputs are registered.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- Step token:
  - Set by i_step when i_mode=1; holds a single token, so extra pulses are dropped.
  - Cleared by a grant.
  - Cleared when i_mode=0.
- IDLE, eligible when i_tx_busy=0 and (i_mode=0 or token=1):
  - fifo_req = i_fifo_empty_n; inj_req = i_inj_valid.
  - One request: grant it.
  - Both requesting: grant the source the pointer names, then move the pointer to the other source.
  - On grant: capture the granted byte into o_tx_data, go to SEND.
- SEND (1 cycle):
  - o_tx_wr=1.
  - FIFO grant: o_fifo_rd=1. Injection grant: o_inj_ready=1.
  - o_count+=1.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for i_tx_busy=1, then go to WAIT_DONE.
  - If busy has not risen after 4 cycles, go to WAIT_DONE anyway; this tolerates a transmitter that latches without asserting busy.
- WAIT_DONE:
  - On i_tx_busy=0: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
- Latency: byte present and eligible in IDLE at cycle t → o_tx_wr and the pop/accept at t+1.
- No new grant is made until the previous byte's busy has dropped, so the FIFO is never popped twice for one transmission.
- Step with nothing pending (i_mode=1, i_step=1, state IDLE, no requests):
  - o_empty_hit pulses next cycle.
  - o_tx_data cleared to 0 (LEDs off).
  - Token not retained.
- Step while not in IDLE: token is retained and served when IDLE is reached.
- Mode switches 1→0 mid-transfer: the current byte completes, then auto drain begins.
- i_fifo_empty_n dropping between grant and SEND cannot occur (only this block pops); the captured byte is always used.
- Injection requester must hold i_inj_valid/i_inj_data until o_inj_ready.
- o_count wraps from all-ones to 0.
- Reset mid-transfer: immediate return to reset values; any transmitter frame in flight is not tracked.

Test Plan:
- Auto mode, FIFO preloaded 0x41,0x42,0x43, busy modelled 10 cycles after each wr → three o_tx_wr with data 0x41,0x42,0x43, exactly three o_fifo_rd, o_count=3, no wr while busy=1.
- Step mode, FIFO holds 0x55, no step → no wr for 200 cycles. One i_step → one wr of 0x55, one pop. Second i_step with FIFO empty → o_empty_hit pulse, o_tx_data=0x00.
- FIFO (0x10,0x11) and injection (0xA5) both pending, pointer=FIFO → wr order 0x10, 0xA5, 0x11; o_inj_ready single pulse coincident with the 0xA5 wr.
- Step mode, three i_step pulses during one busy window with FIFO holding 4 bytes → only one further byte sent after busy falls.
- GAP_CYCLES=5 → exactly 5 idle clocks between busy fall and the next o_tx_wr. Busy never asserted → WAIT_BUSY times out after 4 cycles and flow continues.
- i_rst_n low mid-WAIT_DONE with token set → all outputs 0, o_count=0. After release, auto drain resumes from the current FIFO head.
